// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing generator with a byte-wide CPU register port.
// Define LINE_IRQ_EN to build the programmable line-compare interrupt (LCMP, irq_en, irq_pending).
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       ce,
  input  logic       wren,
  input  logic       ren,
  input  logic [1:0] addr,
  input  logic [7:0] from_cpu,
  output logic [7:0] to_cpu,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_LCMP_LO = 2'd1;
  localparam logic [1:0] A_LCMP_HI = 2'd2;
  localparam logic [1:0] A_STAT    = 2'd3;

  // Bus strobes: a register access needs ce together with its strobe.
  logic wr_en;
  logic rd_en;
  assign wr_en = ce & wren;
  assign rd_en = ce & ren;

  logic       run_q, run_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_q, blank_d;
  logic [7:0] to_cpu_q, to_cpu_d;

  logic       adv;
  logic       h_wrap;

  // Values seen by the read mux; tied off when the interrupt block is absent.
  logic       irq_en_v;
  logic [9:0] lcmp_v;
  logic       pend_v;

  always_comb begin
    run_d = run_q;
    if (wr_en && addr == A_CTRL) begin
      run_d = from_cpu[0];
    end
  end

  // Advance uses the current run; clearing run zeroes the raster on the write edge,
  // and setting it starts counting one cycle later, so the raster restarts at (0,0).
  assign adv    = run_q & pix_en;
  assign h_wrap = adv & (h_q == H_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_d) begin
      h_d = '0;
      v_d = '0;
    end else if (adv) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Sync and blank decode from the next-state counters so they line up with x/y.
  always_comb begin
    hsync_d = ~(run_d && (h_d >= HS_BEG) && (h_d < HS_END));
    vsync_d = ~(run_d && (v_d >= VS_BEG) && (v_d < VS_END));
    blank_d = ~run_d | (h_d >= H_VIS) | (v_d >= V_VIS);
  end

`ifdef LINE_IRQ_EN
  logic       irq_en_q, irq_en_d;
  logic [9:0] lcmp_q, lcmp_d;
  logic       pend_q, pend_d;
  logic       line_hit;
  logic       pend_clr;

  always_comb begin
    irq_en_d = irq_en_q;
    lcmp_d   = lcmp_q;
    if (wr_en) begin
      case (addr)
        A_CTRL:    irq_en_d = from_cpu[1];
        A_LCMP_LO: lcmp_d[7:0] = from_cpu;
        A_LCMP_HI: lcmp_d[9:8] = from_cpu[1:0];
        default:   ;
      endcase
    end
  end

  // Matches only on the wrap into a new line; an LCMP beyond the frame never equals v_d.
  assign line_hit = run_d & h_wrap & (v_d == lcmp_q);
  assign pend_clr = wr_en & (addr == A_STAT);

  always_comb begin
    pend_d = pend_q;
    if (line_hit && irq_en_q) begin
      pend_d = 1'b1;
    end else if (pend_clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      lcmp_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      lcmp_q   <= lcmp_d;
      pend_q   <= pend_d;
    end
  end

  assign irq_en_v = irq_en_q;
  assign lcmp_v   = lcmp_q;
  assign pend_v   = pend_q;
  assign line_irq = pend_q;
`else
  logic unused_wdata;
  assign unused_wdata = ^from_cpu[7:1];

  assign irq_en_v = 1'b0;
  assign lcmp_v   = '0;
  assign pend_v   = 1'b0;
  assign line_irq = 1'b0;
`endif

  // Read data is captured from pre-edge state, giving one clock of latency.
  always_comb begin
    to_cpu_d = to_cpu_q;
    if (rd_en) begin
      case (addr)
        A_CTRL:    to_cpu_d = {6'b0, irq_en_v, run_q};
        A_LCMP_LO: to_cpu_d = lcmp_v[7:0];
        A_LCMP_HI: to_cpu_d = {6'b0, lcmp_v[9:8]};
        default:   to_cpu_d = {3'b0, (v_q >= V_VIS), pend_v, ~hsync_q, ~vsync_q, blank_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b1;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      blank_q  <= 1'b0;
      to_cpu_q <= 8'h00;
    end else begin
      run_q    <= run_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      blank_q  <= blank_d;
      to_cpu_q <= to_cpu_d;
    end
  end

  assign to_cpu = to_cpu_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign blank  = blank_q;
  assign x      = h_q;
  assign y      = v_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance plus a shrunken-timing instance share the bus,
// both checked every cycle against a frame-position model, with a register table and corner sequences.
module tb_vga_sync_gen;

`ifdef LINE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  typedef struct {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
  } tim_t;

  function automatic tim_t tim(input int i);
    tim_t t;
    if (i == 0) t = '{640, 16, 96, 48, 480, 10, 2, 33};
    else        t = '{8, 2, 3, 2, 6, 2, 2, 3};
    return t;
  endfunction

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic       rst, pix_en, ce, wren, ren;
  logic [1:0] addr;
  logic [7:0] from_cpu;
  logic [7:0] to_cpu [2];
  logic       hsync [2];
  logic       vsync [2];
  logic       blank [2];
  logic [9:0] x [2];
  logic [9:0] y [2];
  logic       line_irq [2];

  always #5 clk = ~clk;

  vga_sync_gen u_full (
    .clk(clk), .rst(rst), .pix_en(pix_en), .ce(ce), .wren(wren), .ren(ren),
    .addr(addr), .from_cpu(from_cpu), .to_cpu(to_cpu[0]), .hsync(hsync[0]),
    .vsync(vsync[0]), .blank(blank[0]), .x(x[0]), .y(y[0]), .line_irq(line_irq[0])
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .ce(ce), .wren(wren), .ren(ren),
    .addr(addr), .from_cpu(from_cpu), .to_cpu(to_cpu[1]), .hsync(hsync[1]),
    .vsync(vsync[1]), .blank(blank[1]), .x(x[1]), .y(y[1]), .line_irq(line_irq[1])
  );

  // ---------------- reference model: raster as a linear frame position ----------------
  int         m_pos [2];
  logic       m_pend [2];
  logic [7:0] m_to_cpu [2];
  logic       m_run, m_irq_en;
  logic [9:0] m_lcmp;

  int n_tests = 0;
  int n_fail  = 0;
  int nt      = 0;

  function automatic void decode(input int i, output logic [9:0] ex, output logic [9:0] ey,
                                 output logic hs, output logic vs, output logic bl);
    tim_t t;
    int ht, px, py;
    t  = tim(i);
    ht = t.ha + t.hf + t.hs + t.hb;
    px = m_pos[i] % ht;
    py = m_pos[i] / ht;
    ex = 10'(px);
    ey = 10'(py);
    hs = !(m_run && px >= t.ha + t.hf && px < t.ha + t.hf + t.hs);
    vs = !(m_run && py >= t.va + t.vf && py < t.va + t.vf + t.vs);
    bl = !m_run || px >= t.ha || py >= t.va;
  endfunction

  function automatic void model_step(input logic r, input logic c, input logic w, input logic rd,
                                     input logic [1:0] a, input logic [7:0] d, input logic p);
    logic new_run;
    if (r) begin
      m_run = 1'b1; m_irq_en = 1'b0; m_lcmp = '0;
      for (int i = 0; i < 2; i++) begin
        m_pos[i] = 0; m_pend[i] = 1'b0; m_to_cpu[i] = 8'h00;
      end
      return;
    end
    new_run = (c && w && a == 2'd0) ? d[0] : m_run;
    for (int i = 0; i < 2; i++) begin
      tim_t t;
      logic [9:0] ex, ey;
      logic hs, vs, bl, adv;
      int ht, frame, np;
      t     = tim(i);
      ht    = t.ha + t.hf + t.hs + t.hb;
      frame = ht * (t.va + t.vf + t.vs + t.vb);
      decode(i, ex, ey, hs, vs, bl);
      if (c && rd) begin
        case (a)
          2'd0:    m_to_cpu[i] = {6'b0, IRQ & m_irq_en, m_run};
          2'd1:    m_to_cpu[i] = IRQ ? m_lcmp[7:0] : 8'h00;
          2'd2:    m_to_cpu[i] = IRQ ? {6'b0, m_lcmp[9:8]} : 8'h00;
          default: m_to_cpu[i] = {3'b0, (int'(ey) >= t.va), m_pend[i], !hs, !vs, bl};
        endcase
      end
      np  = m_pos[i];
      adv = 1'b0;
      if (!new_run) np = 0;
      else if (m_run && p) begin
        np  = (np + 1) % frame;
        adv = 1'b1;
      end
      if (IRQ && adv && m_irq_en && np == int'(m_lcmp) * ht) m_pend[i] = 1'b1;
      else if (c && w && a == 2'd3) m_pend[i] = 1'b0;
      m_pos[i] = np;
    end
    if (c && w) begin
      case (a)
        2'd0: begin m_run = d[0]; m_irq_en = IRQ & d[1]; end
        2'd1: if (IRQ) m_lcmp[7:0] = d;
        2'd2: if (IRQ) m_lcmp[9:8] = d[1:0];
        default: ;
      endcase
    end
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic note_fail();
    n_fail++;
    if (n_fail >= 40) summary_and_finish();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      note_fail();
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      logic [9:0] ex, ey;
      logic hs, vs, bl;
      logic [31:0] got, want;
      decode(i, ex, ey, hs, vs, bl);
      got  = {to_cpu[i], hsync[i], vsync[i], blank[i], x[i], y[i], line_irq[i]};
      want = {m_to_cpu[i], hs, vs, bl, ex, ey, m_pend[i]};
      n_tests++;
      if (got !== want) begin
        $display("FAIL cycle dut%0d t=%0t got to_cpu=%h hs=%b vs=%b blank=%b x=%0d y=%0d irq=%b, expected to_cpu=%h hs=%b vs=%b blank=%b x=%0d y=%0d irq=%b",
                 i, $time, to_cpu[i], hsync[i], vsync[i], blank[i], x[i], y[i], line_irq[i],
                 m_to_cpu[i], hs, vs, bl, ex, ey, m_pend[i]);
        note_fail();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic r, input logic c, input logic w, input logic rd,
                      input logic [1:0] a, input logic [7:0] d, input logic p);
    rst = r; ce = c; wren = w; ren = rd; addr = a; from_cpu = d; pix_en = p;
    model_step(r, c, w, rd, a, d, p);
    @(posedge clk);
    #1;
    if (p) nt++;
    check_cycle();
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    nt = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic p);
    tick(1'b0, 1'b1, 1'b1, 1'b0, a, d, p);
  endtask

  task automatic rd(input logic [1:0] a, input logic p);
    tick(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00, p);
  endtask

  task automatic run_to(input int target);
    while (nt < target) tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
  endtask

  typedef struct {
    logic       ce;
    logic       wren;
    logic       ren;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic w, input logic r, input logic [1:0] a,
                              input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v = '{c, w, r, a, d, e};
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs [15];
    int   cnt_vs, cnt_bl, cnt_irq;

    rst = 1'b1; pix_en = 1'b0; ce = 1'b0; wren = 1'b0; ren = 1'b0; addr = 2'd0; from_cpu = 8'h00;
    do_reset();
    do_reset();
    chk("reset_state", 32'({to_cpu[0], hsync[0], vsync[0], blank[0], x[0], y[0], line_irq[0]}),
        32'({8'h00, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0}));

    // Register table, counters held (pix_en=0); exp_rd is to_cpu after each edge.
    vecs[0]  = mk(1, 0, 1, 2'd0, 8'h00, 8'h01);
    vecs[1]  = mk(1, 1, 0, 2'd0, 8'h03, 8'h01);
    vecs[2]  = mk(1, 0, 1, 2'd0, 8'h00, IRQ ? 8'h03 : 8'h01);
    vecs[3]  = mk(1, 1, 0, 2'd1, 8'hA5, IRQ ? 8'h03 : 8'h01);
    vecs[4]  = mk(1, 0, 1, 2'd1, 8'h00, IRQ ? 8'hA5 : 8'h00);
    vecs[5]  = mk(1, 1, 0, 2'd2, 8'hFF, IRQ ? 8'hA5 : 8'h00);
    vecs[6]  = mk(1, 0, 1, 2'd2, 8'h00, IRQ ? 8'h03 : 8'h00);
    vecs[7]  = mk(1, 0, 1, 2'd3, 8'h00, 8'h00);
    vecs[8]  = mk(1, 1, 0, 2'd0, 8'h00, 8'h00);
    vecs[9]  = mk(1, 0, 1, 2'd3, 8'h00, 8'h01);
    vecs[10] = mk(0, 0, 1, 2'd0, 8'h00, 8'h01);
    vecs[11] = mk(0, 1, 0, 2'd0, 8'h01, 8'h01);
    vecs[12] = mk(1, 0, 1, 2'd0, 8'h00, 8'h00);
    vecs[13] = mk(1, 1, 0, 2'd0, 8'h01, 8'h00);
    vecs[14] = mk(1, 0, 1, 2'd0, 8'h00, 8'h01);
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, vecs[k].ce, vecs[k].wren, vecs[k].ren, vecs[k].addr, vecs[k].data, 1'b0);
      chk($sformatf("reg_vec%0d", k), 32'(to_cpu[0]), 32'(vecs[k].exp_rd));
    end

    // Horizontal timing on the full-size raster, frame wrap on the small one.
    do_reset();
    run_to(655);
    chk("hs_before_656", 32'({x[0], hsync[0]}), 32'({10'd655, 1'b1}));
    run_to(656);
    chk("hs_fall_656", 32'({x[0], hsync[0]}), 32'({10'd656, 1'b0}));
    run_to(751);
    chk("hs_low_751", 32'({x[0], hsync[0]}), 32'({10'd751, 1'b0}));
    run_to(752);
    chk("hs_rise_752", 32'({x[0], hsync[0]}), 32'({10'd752, 1'b1}));
    run_to(799);
    chk("line_end", 32'({x[0], y[0], blank[0]}), 32'({10'd799, 10'd0, 1'b1}));
    run_to(800);
    chk("line_wrap", 32'({x[0], y[0], blank[0]}), 32'({10'd0, 10'd1, 1'b0}));
    chk("small_pos_800", 32'({x[1], y[1]}), 32'({10'd5, 10'd1}));
    cnt_vs = 0;
    cnt_bl = 0;
    for (int k = 0; k < 195; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      cnt_vs += int'(!vsync[1]);
      cnt_bl += int'(blank[1]);
      if (nt == 974) chk("small_frame_end", 32'({x[1], y[1]}), 32'({10'd14, 10'd12}));
      if (nt == 975) chk("small_frame_wrap", 32'({x[1], y[1]}), 32'({10'd0, 10'd0}));
    end
    chk("small_vsync_cycles", 32'(cnt_vs), 32'd30);
    chk("small_blank_cycles", 32'(cnt_bl), 32'd147);

    // Pixel enable every 4th clock: small frame period is 780 clocks.
    do_reset();
    for (int k = 0; k < 780; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, (k % 4) == 3);
      if (k == 778) chk("slow_frame_end", 32'({x[1], y[1]}), 32'({10'd14, 10'd12}));
      if (k == 779) chk("slow_frame_wrap", 32'({x[1], y[1], x[0]}), 32'({10'd0, 10'd0, 10'd195}));
    end

`ifdef LINE_IRQ_EN
    do_reset();
    wr(2'd0, 8'h03, 1'b0);
    wr(2'd1, 8'h02, 1'b0);
    wr(2'd2, 8'h00, 1'b0);
    nt = 0;
    run_to(29);
    chk("irq_before_line", 32'(line_irq[1]), 32'd0);
    run_to(30);
    chk("irq_at_line", 32'({line_irq[1], x[1], y[1]}), 32'({1'b1, 10'd0, 10'd2}));
    tick(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 1'b1);
    chk("status_pending", 32'({to_cpu[1][3], to_cpu[0][3]}), 32'({1'b1, 1'b0}));
    tick(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h5A, 1'b1);
    chk("irq_clear", 32'(line_irq[1]), 32'd0);
    run_to(224);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1);
    chk("set_beats_clear", 32'({line_irq[1], x[1], y[1]}), 32'({1'b1, 10'd0, 10'd2}));
    tick(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1);
    chk("irq_clear_again", 32'(line_irq[1]), 32'd0);
    run_to(1599);
    chk("full_irq_before", 32'(line_irq[0]), 32'd0);
    run_to(1600);
    chk("full_irq_at_line", 32'({line_irq[0], x[0], y[0]}), 32'({1'b1, 10'd0, 10'd2}));
`else
    do_reset();
    wr(2'd1, 8'h00, 1'b0);
    wr(2'd2, 8'h00, 1'b0);
    wr(2'd0, 8'h03, 1'b0);
    cnt_irq = 0;
    for (int k = 0; k < 390; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      cnt_irq += int'(line_irq[0] | line_irq[1]);
    end
    chk("no_irq_two_frames", 32'(cnt_irq), 32'd0);
    wr(2'd1, 8'hFF, 1'b0);
    rd(2'd1, 1'b0);
    chk("lcmp_reads_zero", 32'(to_cpu[0]), 32'd0);
    rd(2'd0, 1'b0);
    chk("ctrl_bit1_zero", 32'(to_cpu[0]), 32'h01);
`endif

    // Reset mid-frame with bus activity, then run stop/restart.
    tick(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b1);
    nt = 0;
    chk("mid_reset", 32'({to_cpu[0], x[0], y[0], line_irq[0], blank[0]}),
        32'({8'h00, 10'd0, 10'd0, 1'b0, 1'b0}));
    run_to(300);
    wr(2'd0, 8'h00, 1'b1);
    chk("stop_outputs", 32'({x[0], y[0], hsync[0], vsync[0], blank[0]}),
        32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("stopped_hold", 32'({x[0], y[0]}), 32'd0);
    wr(2'd0, 8'h01, 1'b1);
    chk("restart_origin", 32'({x[0], y[0], hsync[0], blank[0]}), 32'({10'd0, 10'd0, 1'b1, 1'b0}));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("restart_count", 32'(x[0]), 32'd1);

    // Randomized bus and pixel traffic; the per-cycle model check does the work.
    wr(2'd0, 8'h03, 1'b0);
    wr(2'd1, 8'h05, 1'b0);
    wr(2'd2, 8'h00, 1'b0);
    for (int k = 0; k < 12000; k++) begin
      logic r, c, w, rv, p;
      logic [1:0] a;
      logic [7:0] d;
      r  = ($urandom_range(0, 1999) == 0);
      c  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      if (a == 2'd0 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
      if (a == 2'd1) d = 8'($urandom_range(0, 14));
      if (a == 2'd2 && $urandom_range(0, 7) != 0) d = 8'h00;
      p  = ($urandom_range(0, 3) != 0);
      tick(r, c, w, rv, a, d, p);
    end

    summary_and_finish();
  end

endmodule
